branch_history_predictor: RTL and testbench

// Parametrised successor to the single-branch jump predictor: a direct-mapped table of

---
 rtl/branch_history_predictor.sv | 185 ++++++++++++++++++
 tb/tb_branch_history_predictor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_predictor.sv
// Direct-mapped table of saturating branch counters indexed by PC, with a clear walk,
// EX-stage training, mispredict redirect and saturating performance counters.
module branch_history_predictor #(
    parameter int PC_SIZE    = 12,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_table_i,
    output logic                 busy_o,
    input  logic                 lookup_is_branch_i,
    input  logic [PC_SIZE-1:0]   lookup_pc_i,
    input  logic [PC_SIZE-1:0]   lookup_target_i,
    input  logic [PC_SIZE-1:0]   lookup_fallthru_i,
    output logic                 predict_taken_o,
    output logic [PC_SIZE-1:0]   next_pc_o,
    input  logic                 update_valid_i,
    input  logic [PC_SIZE-1:0]   update_pc_i,
    input  logic                 update_taken_i,
    input  logic                 update_pred_i,
    input  logic [PC_SIZE-1:0]   update_target_i,
    input  logic [PC_SIZE-1:0]   update_fallthru_i,
    output logic                 clear_if_o,
    output logic [PC_SIZE-1:0]   redirect_pc_o,
    output logic [STAT_BITS-1:0] perf_branches_o,
    output logic [STAT_BITS-1:0] perf_mispred_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   CTR_WNT   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]   CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_ZERO  = {CTR_BITS{1'b0}};
    localparam logic [STAT_BITS-1:0]  STAT_MAX  = {STAT_BITS{1'b1}};
    localparam logic [STAT_BITS-1:0]  STAT_ZERO = {STAT_BITS{1'b0}};
    localparam logic [INDEX_BITS-1:0] WALK_LAST = {INDEX_BITS{1'b1}};
    localparam logic [INDEX_BITS-1:0] WALK_ZERO = {INDEX_BITS{1'b0}};
    localparam logic [PC_SIZE-1:0]    PC_ZERO   = {PC_SIZE{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [INDEX_BITS-1:0] walk_q;
    logic [INDEX_BITS-1:0] walk_d;
    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [STAT_BITS-1:0]  perf_br_q;
    logic [STAT_BITS-1:0]  perf_br_d;
    logic [STAT_BITS-1:0]  perf_mp_q;
    logic [STAT_BITS-1:0]  perf_mp_d;

    logic                  tbl_we_s;
    logic [INDEX_BITS-1:0] tbl_waddr_s;
    logic [CTR_BITS-1:0]   tbl_wdata_s;
    logic [INDEX_BITS-1:0] lookup_idx_s;
    logic [INDEX_BITS-1:0] update_idx_s;
    logic                  mispredict_s;
    logic                  unused_pc_bits_s;

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                     input logic              taken);
        logic [CTR_BITS-1:0] res;
        if (taken) begin
            res = (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        end else begin
            res = (ctr == CTR_ZERO) ? ctr : ctr - CTR_BITS'(1);
        end
        return res;
    endfunction

    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] cnt,
                                                      input logic               en);
        logic [STAT_BITS-1:0] res;
        if (en && (cnt != STAT_MAX)) begin
            res = cnt + STAT_BITS'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Word-aligned PC bits select the table entry; the remaining bits alias freely.
    assign lookup_idx_s     = lookup_pc_i[INDEX_BITS+1:2];
    assign update_idx_s     = update_pc_i[INDEX_BITS+1:2];
    assign unused_pc_bits_s = ^{lookup_pc_i, update_pc_i};

    assign busy_o          = (state_q == ST_CLEAR);
    assign perf_branches_o = perf_br_q;
    assign perf_mispred_o  = perf_mp_q;

    // IF-stage prediction from the stored counter MSB, masked while the table is clearing
    always_comb begin
        predict_taken_o = 1'b0;
        if (lookup_is_branch_i && (state_q == ST_RUN)) begin
            predict_taken_o = table_q[lookup_idx_s][CTR_BITS-1];
        end else begin
            predict_taken_o = 1'b0;
        end
        next_pc_o = predict_taken_o ? lookup_target_i : lookup_fallthru_i;
    end

    // EX-stage mispredict detection, valid in every state
    always_comb begin
        mispredict_s  = update_valid_i & (update_taken_i ^ update_pred_i);
        redirect_pc_o = PC_ZERO;
        if (mispredict_s) begin
            redirect_pc_o = update_taken_i ? update_target_i : update_fallthru_i;
        end else begin
            redirect_pc_o = PC_ZERO;
        end
        clear_if_o = mispredict_s;
    end

    // Next state, table write port and perf counter updates
    always_comb begin
        state_d     = state_q;
        walk_d      = walk_q;
        tbl_we_s    = 1'b0;
        tbl_waddr_s = walk_q;
        tbl_wdata_s = CTR_WNT;
        perf_br_d   = perf_br_q;
        perf_mp_d   = perf_mp_q;
        case (state_q)
            ST_CLEAR: begin
                tbl_we_s    = 1'b1;
                tbl_waddr_s = walk_q;
                tbl_wdata_s = CTR_WNT;
                walk_d      = walk_q + INDEX_BITS'(1);
                if (walk_q == WALK_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (update_valid_i) begin
                    tbl_we_s    = 1'b1;
                    tbl_waddr_s = update_idx_s;
                    tbl_wdata_s = ctr_next(table_q[update_idx_s], update_taken_i);
                end else begin
                    tbl_we_s    = 1'b0;
                end
                perf_br_d = stat_inc(perf_br_q, update_valid_i);
                perf_mp_d = stat_inc(perf_mp_q, mispredict_s);
                if (flush_table_i) begin
                    state_d = ST_CLEAR;
                    walk_d  = WALK_ZERO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                walk_d  = WALK_ZERO;
            end
        endcase
    end

    // Control and perf counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            walk_q    <= WALK_ZERO;
            perf_br_q <= STAT_ZERO;
            perf_mp_q <= STAT_ZERO;
        end else begin
            state_q   <= state_d;
            walk_q    <= walk_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    // Counter table storage; contents are made valid by the clear walk, not by reset
    always_ff @(posedge clk_i) begin
        if (tbl_we_s) begin
            table_q[tbl_waddr_s] <= tbl_wdata_s;
        end
    end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed and randomized bench for branch_history_predictor, checked against a
// behavioural table model at every cycle.
module tb_branch_history_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        lib;
    logic [11:0] lpc, ltgt, lft;
    logic        uv, ut, up;
    logic [11:0] upc, utgt, uft;

    logic        busy, pt, cif;
    logic [11:0] npc, rpc;
    logic [15:0] pbr, pmp;
    logic        busy4, pt4, cif4;
    logic [11:0] npc4, rpc4;
    logic [3:0]  pbr4, pmp4;

    int n_assert = 0;
    int n_fail   = 0;

    int mctr [64];
    int clear_left;
    int m_br;
    int m_mp;

    always #5 clk = ~clk;

    branch_history_predictor #(.PC_SIZE(12), .INDEX_BITS(6), .CTR_BITS(2), .STAT_BITS(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_table_i(flush), .busy_o(busy),
        .lookup_is_branch_i(lib), .lookup_pc_i(lpc), .lookup_target_i(ltgt),
        .lookup_fallthru_i(lft), .predict_taken_o(pt), .next_pc_o(npc),
        .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut), .update_pred_i(up),
        .update_target_i(utgt), .update_fallthru_i(uft), .clear_if_o(cif),
        .redirect_pc_o(rpc), .perf_branches_o(pbr), .perf_mispred_o(pmp)
    );

    branch_history_predictor #(.PC_SIZE(12), .INDEX_BITS(6), .CTR_BITS(2), .STAT_BITS(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_table_i(flush), .busy_o(busy4),
        .lookup_is_branch_i(lib), .lookup_pc_i(lpc), .lookup_target_i(ltgt),
        .lookup_fallthru_i(lft), .predict_taken_o(pt4), .next_pc_o(npc4),
        .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut), .update_pred_i(up),
        .update_target_i(utgt), .update_fallthru_i(uft), .clear_if_o(cif4),
        .redirect_pc_o(rpc4), .perf_branches_o(pbr4), .perf_mispred_o(pmp4)
    );

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clearing the table is invisible while busy, so the model sets every entry at once.
    task automatic model_clear();
        clear_left = 64;
        foreach (mctr[i]) mctr[i] = 1;
    endtask

    task automatic model_reset();
        model_clear();
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_edge();
        int i;
        if (rst) begin
            model_reset();
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (uv) begin
                i = (int'(upc) / 4) % 64;
                mctr[i] = ut ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
                m_br++;
                if (ut != up) m_mp++;
            end
            if (flush) model_clear();
        end
    endtask

    task automatic check_all(input string tag);
        logic        busy_e, pt_e, ci_e;
        logic [11:0] np_e, rp_e;
        busy_e = (clear_left > 0);
        pt_e   = lib && !busy_e && (mctr[(int'(lpc) / 4) % 64] >= 2);
        np_e   = pt_e ? ltgt : lft;
        ci_e   = uv && (ut != up);
        rp_e   = ci_e ? (ut ? utgt : uft) : 12'h000;
        chk({tag, ".busy"}, 32'(busy), 32'(busy_e));
        chk({tag, ".predict"}, 32'(pt), 32'(pt_e));
        chk({tag, ".next_pc"}, 32'(npc), 32'(np_e));
        chk({tag, ".clear_if"}, 32'(cif), 32'(ci_e));
        chk({tag, ".redirect"}, 32'(rpc), 32'(rp_e));
        chk({tag, ".perf_br"}, 32'(pbr), 32'(sat(m_br, 16)));
        chk({tag, ".perf_mp"}, 32'(pmp), 32'(sat(m_mp, 16)));
        chk({tag, ".perf_br4"}, 32'(pbr4), 32'(sat(m_br, 4)));
        chk({tag, ".perf_mp4"}, 32'(pmp4), 32'(sat(m_mp, 4)));
    endtask

    task automatic half1(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic half2();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle(input string tag);
        half1(tag);
        half2();
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            cycle("clear");
            n++;
        end
        chk(tag, 32'(n), 32'd64);
    endtask

    task automatic set_lookup(input logic [11:0] pc, input logic [11:0] tgt);
        lib  = 1'b1;
        lpc  = pc;
        ltgt = tgt;
        lft  = pc + 12'd4;
    endtask

    task automatic set_update(input logic [11:0] pc, input logic taken, input logic pred,
                              input logic [11:0] tgt);
        uv   = 1'b1;
        upc  = pc;
        ut   = taken;
        up   = pred;
        utgt = tgt;
        uft  = pc + 12'd4;
    endtask

    task automatic upd(input logic [11:0] pc, input logic taken);
        set_update(pc, taken, taken, 12'h200);
        cycle("upd");
        uv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; uv = 1'b0; ut = 1'b0; up = 1'b0;
        upc = 12'h000; utgt = 12'h000; uft = 12'h004;
        set_lookup(12'h040, 12'h300);
        model_reset();

        // Reset state and a reset during the clear walk
        half1("reset");
        chk("reset.busy", 32'(busy), 32'd1);
        chk("reset.predict", 32'(pt), 32'd0);
        half2();
        cycle("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle("walk");
        rst = 1'b1;
        model_reset();
        cycle("midclear_rst");
        cycle("midclear_rst");
        rst = 1'b0;
        wait_clear("busy_len_after_reset");

        // Training to saturation and hysteresis
        set_lookup(12'h040, 12'h300);
        upd(12'h040, 1'b1);
        upd(12'h040, 1'b1);
        half1("train2");
        chk("train2.predict", 32'(pt), 32'd1);
        chk("train2.next_pc", 32'(npc), 32'h300);
        half2();
        for (int i = 0; i < 3; i++) upd(12'h040, 1'b1);
        upd(12'h040, 1'b0);
        half1("hyst");
        chk("hyst.predict", 32'(pt), 32'd1);
        half2();

        // Mispredict redirect
        set_update(12'h0C0, 1'b1, 1'b0, 12'h120);
        half1("mispred");
        chk("mispred.clear_if", 32'(cif), 32'd1);
        chk("mispred.redirect", 32'(rpc), 32'h120);
        half2();
        uv = 1'b0;
        half1("mispred_cnt");
        chk("mispred.perf", 32'(pmp), 32'(m_mp));
        half2();

        // Aliasing, then same-cycle update and lookup
        upd(12'h004, 1'b1);
        set_lookup(12'h104, 12'h400);
        half1("alias");
        chk("alias.predict", 32'(pt), 32'd1);
        half2();
        set_update(12'h004, 1'b0, 1'b1, 12'h200);
        half1("bypass");
        chk("bypass.old_value", 32'(pt), 32'd1);
        half2();
        uv = 1'b0;
        half1("after_bypass");
        chk("bypass.new_value", 32'(pt), 32'd0);
        half2();

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            lib   = 1'($urandom_range(0, 3) != 0);
            lpc   = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) * 256);
            ltgt  = 12'($urandom);
            lft   = lpc + 12'd4;
            uv    = 1'($urandom_range(0, 1));
            upc   = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) * 256);
            ut    = 1'($urandom_range(0, 1));
            up    = 1'($urandom_range(0, 1));
            utgt  = 12'($urandom);
            uft   = upc + 12'd4;
            flush = 1'($urandom_range(0, 49) == 0);
            cycle("rand");
        end
        flush = 1'b0;
        uv    = 1'b0;
        for (int n = 0; n < 200 && busy === 1'b1; n++) cycle("drain");
        chk("drain.idle", 32'(busy), 32'd0);

        // Flush after training
        upd(12'h040, 1'b1);
        upd(12'h040, 1'b1);
        set_lookup(12'h040, 12'h300);
        half1("pre_flush");
        chk("pre_flush.predict", 32'(pt), 32'd1);
        half2();
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        wait_clear("busy_len_after_flush");
        for (int i = 0; i < 64; i++) begin
            set_lookup(12'(i * 4), 12'h3F0);
            half1("post_flush");
            chk("post_flush.predict", 32'(pt), 32'd0);
            half2();
        end

        // Reset in RUN clears perf immediately, then saturation of the 4-bit counters
        set_update(12'h010, 1'b1, 1'b0, 12'h050);
        rst = 1'b1;
        model_reset();
        half1("run_rst");
        chk("run_rst.perf_br", 32'(pbr), 32'd0);
        chk("run_rst.busy", 32'(busy), 32'd1);
        half2();
        uv  = 1'b0;
        rst = 1'b0;
        wait_clear("busy_len_after_run_reset");
        for (int i = 0; i < 20; i++) begin
            set_update(12'(i * 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'h080);
            cycle("stat");
        end
        uv = 1'b0;
        half1("stat_end");
        chk("stat4.perf_br", 32'(pbr4), 32'd15);
        chk("stat16.perf_br", 32'(pbr), 32'd20);
        half2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
